// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch stage: FSM states, next-pc select codes,
// the NOP bubble word and the sequential PC increment.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DROP,
    VALID
  } fetch_state_e;

  typedef enum logic [1:0] {
    SEL_HOLD,
    SEL_INC,
    SEL_REDIR,
    SEL_LATCHED
  } pc_sel_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam int unsigned PC_INCR   = 4;

endpackage

// File: rtl/fetch_if.sv
// Request/acknowledge read channel between the fetch unit (master) and instruction memory (slave).
interface fetch_if #(
  parameter int unsigned DATA_WIDTH = 32
) ();

  logic                  req;
  logic [DATA_WIDTH-1:0] addr;
  logic                  ack;
  logic [DATA_WIDTH-1:0] rdata;

  modport master (
    output req,
    output addr,
    input  ack,
    input  rdata
  );

  modport slave (
    input  req,
    input  addr,
    output ack,
    output rdata
  );

endinterface

// File: rtl/fetch_pc_reg.sv
// Program counter with its next-pc mux (hold / +4 / redirect / latched redirect) and the
// latched-redirect register used while a squashed memory read drains.
module fetch_pc_reg
  import fetch_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  pc_sel_e               sel,
  input  logic                  tgt_load,
  input  logic [DATA_WIDTH-1:0] target,
  output logic [DATA_WIDTH-1:0] pc,
  output logic [DATA_WIDTH-1:0] pc_plus4
);

  logic [DATA_WIDTH-1:0] target_aligned;
  logic [DATA_WIDTH-1:0] tgt_q;
  logic [DATA_WIDTH-1:0] pc_n;

  // Redirect targets are word aligned; the increment wraps naturally at 2^DATA_WIDTH.
  assign target_aligned = target & ~DATA_WIDTH'(3);
  assign pc_plus4       = pc + DATA_WIDTH'(PC_INCR);

  always_comb begin
    pc_n = pc;
    unique case (sel)
      SEL_HOLD:    pc_n = pc;
      SEL_INC:     pc_n = pc_plus4;
      SEL_REDIR:   pc_n = target_aligned;
      SEL_LATCHED: pc_n = tgt_q;
      default:     pc_n = pc;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_VECTOR;
    end else begin
      pc <= pc_n;
    end
  end

  always_ff @(posedge clk) begin
    if (tgt_load) begin
      tgt_q <= target_aligned;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, reads instruction memory over a req/ack channel and presents
// InstrF/PCF/PCPlus4F qualified by ValidF. Optional FETCH_PERF_CNT_EN adds fetch/stall counters.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  StallF,
  input  logic                  PCSrcE,
  input  logic [DATA_WIDTH-1:0] PCTargetE,
  fetch_if.master               imem,
  output logic [DATA_WIDTH-1:0] InstrF,
  output logic [DATA_WIDTH-1:0] PCF,
  output logic [DATA_WIDTH-1:0] PCPlus4F,
  output logic                  ValidF
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]           fetch_cnt,
  output logic [31:0]           stall_cnt
`endif
);

  fetch_state_e          state, state_n;
  pc_sel_e               pc_sel;
  logic                  tgt_load;
  logic                  capture;
  logic [DATA_WIDTH-1:0] pc;
  logic [DATA_WIDTH-1:0] pc_plus4;

  fetch_pc_reg #(
    .DATA_WIDTH   (DATA_WIDTH),
    .RESET_VECTOR (RESET_VECTOR)
  ) u_pc_reg (
    .clk      (clk),
    .rst      (rst),
    .sel      (pc_sel),
    .tgt_load (tgt_load),
    .target   (PCTargetE),
    .pc       (pc),
    .pc_plus4 (pc_plus4)
  );

  assign imem.req  = (state == WAIT) || (state == DROP);
  assign imem.addr = pc;
  assign ValidF    = (state == VALID);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // A redirect never changes the address of an outstanding read: the read drains in DROP
  // and its data is discarded; a redirect arriving with that ack wins over the latched one.
  always_comb begin
    state_n  = state;
    pc_sel   = SEL_HOLD;
    tgt_load = 1'b0;
    capture  = 1'b0;
    unique case (state)
      IDLE: state_n = WAIT;
      WAIT: begin
        if (PCSrcE) begin
          tgt_load = 1'b1;
          state_n  = DROP;
        end else if (imem.ack) begin
          capture = 1'b1;
          state_n = VALID;
        end
      end
      DROP: begin
        tgt_load = PCSrcE;
        if (imem.ack) begin
          pc_sel  = PCSrcE ? SEL_REDIR : SEL_LATCHED;
          state_n = WAIT;
        end
      end
      VALID: begin
        if (PCSrcE) begin
          pc_sel  = SEL_REDIR;
          state_n = WAIT;
        end else if (!StallF) begin
          pc_sel  = SEL_INC;
          state_n = WAIT;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      InstrF   <= DATA_WIDTH'(NOP_INSTR);
      PCF      <= RESET_VECTOR;
      PCPlus4F <= RESET_VECTOR + DATA_WIDTH'(PC_INCR);
    end else if (capture) begin
      InstrF   <= imem.rdata;
      PCF      <= pc;
      PCPlus4F <= pc_plus4;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt <= '0;
      stall_cnt <= '0;
    end else if ((state == VALID) && !PCSrcE) begin
      if (StallF) begin
        stall_cnt <= stall_cnt + 32'd1;
      end else begin
        fetch_cnt <= fetch_cnt + 32'd1;
      end
    end
  end
`endif

endmodule
